// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide sequencer owning HI/LO
// Define MDU_MADD_EN to add the madd/maddu/msub accumulate operations.
module mdu_seq #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       mduop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             req,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] mdu_out
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, nxt_cnt;
   logic [WIDTH-1:0]   res_hi, res_lo, nxt_hi, nxt_lo;
   logic               res_wr, nxt_wr;
   logic               is_mult, is_div, launch, mtx_en, commit;
   logic [2*WIDTH-1:0] prod_s, prod_u;
`ifdef MDU_MADD_EN
   logic [2*WIDTH-1:0] acc;
`endif
   logic               sdiv, neg_q, neg_r;
   logic [WIDTH-1:0]   div_n, div_d, quo_u, rem_u, quo, rem;

   always_comb begin
      is_mult = (mduop == OP_MULT) || (mduop == OP_MULTU);
`ifdef MDU_MADD_EN
      is_mult = is_mult || (mduop == OP_MADD) || (mduop == OP_MADDU) || (mduop == OP_MSUB);
`endif
      is_div = (mduop == OP_DIV) || (mduop == OP_DIVU);
   end

   assign launch = (state == IDLE) && start && !req && (is_mult || is_div);
   assign mtx_en = (state == IDLE) && !req;

   // Truncated 2W products of extended operands are exact for both signednesses
   assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`ifdef MDU_MADD_EN
   assign acc    = {hi, lo};
`endif

   // Signed divide on magnitudes; min/-1 falls out as quotient min, remainder 0
   always_comb begin
      sdiv  = (mduop == OP_DIV);
      neg_q = sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r = sdiv && a[WIDTH-1];
      div_n = (sdiv && a[WIDTH-1]) ? -a : a;
      div_d = (sdiv && b[WIDTH-1]) ? -b : b;
      if (div_d == '0) begin
         div_d = {{(WIDTH-1){1'b0}}, 1'b1};
      end
      quo_u = div_n / div_d;
      rem_u = div_n % div_d;
      quo   = neg_q ? -quo_u : quo_u;
      rem   = neg_r ? -rem_u : rem_u;
   end

   always_comb begin
      nxt_hi  = prod_s[2*WIDTH-1:WIDTH];
      nxt_lo  = prod_s[WIDTH-1:0];
      nxt_wr  = 1'b1;
      nxt_cnt = CW'(MULT_CYCLES);
      case (mduop)
         OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
         OP_DIV, OP_DIVU: begin
            nxt_hi  = rem;
            nxt_lo  = quo;
            nxt_wr  = (b != '0);
            nxt_cnt = CW'(DIV_CYCLES);
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {nxt_hi, nxt_lo} = acc + prod_s;
         OP_MADDU: {nxt_hi, nxt_lo} = acc + prod_u;
         OP_MSUB:  {nxt_hi, nxt_lo} = acc - prod_s;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = RUN;
         RUN:     if (cnt == CW'(1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == RUN);
      commit  = (state == RUN) && (cnt == CW'(1));
      mdu_out = '0;
      if (mduop == OP_MFHI) begin
         mdu_out = hi;
      end else if (mduop == OP_MFLO) begin
         mdu_out = lo;
      end
   end

   // res_wr low marks a divide by zero: the slot is spent but HI/LO are kept
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt    <= '0;
         res_hi <= '0;
         res_lo <= '0;
         res_wr <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         if (launch) begin
            cnt    <= nxt_cnt;
            res_hi <= nxt_hi;
            res_lo <= nxt_lo;
            res_wr <= nxt_wr;
         end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
         end
         if (commit) begin
            if (res_wr) begin
               hi <= res_hi;
               lo <= res_lo;
            end
         end else if (mtx_en && (mduop == OP_MTHI)) begin
            hi <= a;
         end else if (mtx_en && (mduop == OP_MTLO)) begin
            lo <= a;
         end
      end
   end
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - randomized scoreboard bench for mdu_seq
module tb_mdu_seq;
   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;
`ifdef MDU_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset, start, req, busy;
   logic [3:0]   mduop;
   logic [W-1:0] a, b, hi, lo, mdu_out;

   mdu_seq #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .mduop(mduop), .a(a), .b(b),
      .req(req), .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] ref_hi, ref_lo;
   bit           busy_q = 1'b0;
   int           run_len = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural result of one operation, from the HI/LO state it starts on
   task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] nh, output logic [W-1:0] nl, output int cyc);
      logic signed [63:0] sx, sy, ps, q, r;
      logic [63:0]        pu, acc;
      sx  = $signed(x);
      sy  = $signed(y);
      ps  = sx * sy;
      pu  = {32'b0, x} * {32'b0, y};
      acc = {ref_hi, ref_lo};
      nh  = ref_hi;
      nl  = ref_lo;
      cyc = MC;
      case (op)
         4'd1:  {nh, nl} = ps;
         4'd2:  {nh, nl} = pu;
         4'd3: begin
            cyc = DC;
            if (y != 0) begin
               q  = sx / sy;
               r  = sx % sy;
               nl = q[31:0];
               nh = r[31:0];
            end
         end
         4'd4: begin
            cyc = DC;
            if (y != 0) begin
               nl = x / y;
               nh = x % y;
            end
         end
         4'd9:  {nh, nl} = acc + ps;
         4'd10: {nh, nl} = acc + pu;
         4'd11: {nh, nl} = acc - ps;
         default: ;
      endcase
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (busy) chk("idle_timeout", {63'b0, busy}, 64'd0);
   endtask

   task automatic launch(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input logic r);
      exp_t         e;
      logic [W-1:0] h, l;
      int           c;
      bit           run;
      wait_idle();
      run = !r && ((op inside {4'd1, 4'd2, 4'd3, 4'd4}) || (MADD && (op inside {4'd9, 4'd10, 4'd11})));
      if (run) begin
         model(op, x, y, h, l, c);
         e.hi = h; e.lo = l; e.cyc = c;
         sb.push_back(e);
         ref_hi = h;
         ref_lo = l;
      end
      start = 1'b1; mduop = op; a = x; b = y; req = r;
      @(posedge clk); #1;
      start = 1'b0; mduop = 4'd0; req = 1'b0;
      if (!run) begin
         chk("no_launch_busy", {63'b0, busy}, 64'd0);
         chk("no_launch_hilo", {hi, lo}, {ref_hi, ref_lo});
      end
   endtask

   task automatic mt(input bit to_hi, input logic [W-1:0] v, input logic r);
      wait_idle();
      mduop = to_hi ? 4'd7 : 4'd8; a = v; req = r;
      @(posedge clk); #1;
      mduop = 4'd0; req = 1'b0;
      if (!r) begin
         if (to_hi) ref_hi = v;
         else ref_lo = v;
      end
      chk(to_hi ? "mthi" : "mtlo", {hi, lo}, {ref_hi, ref_lo});
   endtask

   task automatic mf_check();
      wait_idle();
      mduop = 4'd5; #1;
      chk("mfhi", {32'b0, mdu_out}, {32'b0, ref_hi});
      mduop = 4'd6; #1;
      chk("mflo", {32'b0, mdu_out}, {32'b0, ref_lo});
      mduop = 4'd0; #1;
      chk("mf_none", {32'b0, mdu_out}, 64'd0);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         busy_q  = 1'b0;
         run_len = 0;
      end else begin
         if (busy) begin
            run_len++;
         end else if (busy_q) begin
            if (sb.size() == 0) begin
               chk("unexpected_commit", 64'd1, 64'd0);
            end else begin
               mon_e = sb.pop_front();
               chk("busy_len", 64'(run_len), 64'(mon_e.cyc));
               chk("commit_hi", {32'b0, hi}, {32'b0, mon_e.hi});
               chk("commit_lo", {32'b0, lo}, {32'b0, mon_e.lo});
            end
            run_len = 0;
         end
         busy_q = busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] old_hi, x, y;
      logic [3:0]   op;
      int           sel;
      reset = 1'b0; start = 1'b0; req = 1'b0; mduop = 4'd0; a = '0; b = '0;
      ref_hi = '0; ref_lo = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      launch(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
      wait_idle();
      chk("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
      launch(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
      wait_idle();
      chk("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
      launch(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      wait_idle();
      chk("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      launch(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      wait_idle();
      chk("div_ovf", {hi, lo}, 64'h00000000_80000000);

      // divide by zero, with a stray mthi while running
      launch(4'd4, 32'd5, 32'd0, 1'b0);
      mduop = 4'd7; a = 32'hDEAD;
      @(posedge clk); #1;
      mduop = 4'd0;
      wait_idle();
      chk("divu_zero", {hi, lo}, 64'h00000000_80000000);

      launch(4'd1, 32'd3, 32'd4, 1'b1);
      mt(1'b1, 32'h1234, 1'b1);
      mt(1'b1, 32'h1234, 1'b0);
      chk("mthi_const", {32'b0, hi}, 64'h1234);

      old_hi = ref_hi;
      launch(4'd1, 32'd6, 32'd7, 1'b0);
      mduop = 4'd5; #1;
      chk("mfhi_run", {32'b0, mdu_out}, {32'b0, old_hi});
      start = 1'b1; mduop = 4'd1; a = 32'd9; b = 32'd9;
      repeat (2) begin
         @(posedge clk); #1;
      end
      start = 1'b0; mduop = 4'd0;
      wait_idle();
      chk("run_start_ignored", {hi, lo}, 64'd42);

      mt(1'b1, 32'd0, 1'b0);
      mt(1'b0, 32'hFFFFFFFF, 1'b0);
      launch(4'd10, 32'd1, 32'd1, 1'b0);
      wait_idle();
      chk("maddu", {hi, lo}, MADD ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF);

      for (int i = 12; i < 16; i++) launch(4'(i), 32'd3, 32'd5, 1'b0);
      launch(4'd0, 32'd3, 32'd5, 1'b0);
      mf_check();

      // reset in the middle of a divide must abort it
      launch(4'd3, 32'd100, 32'd7, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      sb.delete();
      ref_hi = '0; ref_lo = '0;
      chk("rst_run_busy", {63'b0, busy}, 64'd0);
      chk("rst_run_hilo", {hi, lo}, 64'd0);
      reset = 1'b1;
      repeat (15) begin
         @(posedge clk); #1;
      end
      chk("rst_no_commit", {hi, lo}, 64'd0);

      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 5) begin
            case ($urandom_range(0, 6))
               0: op = 4'd1;
               1: op = 4'd2;
               2: op = 4'd3;
               3: op = 4'd4;
               4: op = 4'd9;
               5: op = 4'd10;
               default: op = 4'd11;
            endcase
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
               0: y = 32'd0;
               1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
               2: y = $urandom_range(1, 9);
               3: y = -$urandom_range(1, 9);
               default: ;
            endcase
            launch(op, x, y, ($urandom_range(0, 7) == 0));
         end else if (sel <= 7) begin
            mt(sel[0], $urandom, ($urandom_range(0, 3) == 0));
         end else begin
            mf_check();
         end
      end

      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
